// File: rtl/mo_pkg.sv
// Shared definitions for the motion-object line buffer writer.
// Pixel width, object width, FSM encoding and the transparent pixel value.
package mo_pkg;

    localparam int PIX_BITS_DEF = 4;
    localparam int OBJ_W_DEF    = 8;

    localparam logic [PIX_BITS_DEF-1:0] TRANSPARENT = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } mo_state_e;

    function automatic logic is_opaque(input logic [PIX_BITS_DEF-1:0] p);
        return p != TRANSPARENT;
    endfunction

endpackage

// File: rtl/mo_linebuf_ram.sv
// One half of the ping-pong line buffer: 256 x DW.
// Synchronous write port, synchronous read port with read-before-write.
module mo_linebuf_ram
    import mo_pkg::*;
#(
    parameter int DW = PIX_BITS_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [7:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [7:0]    raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [256];
    logic [DW-1:0] rdata_q;

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read data; returns the old word on a same-cycle write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mo_line_buffer_writer.sv
// Plots matched motion-object pixel rows into a ping-pong line buffer
// and reads the other half out clear-on-read. Option: MO_COLLISION_EN.
module mo_line_buffer_writer
    import mo_pkg::*;
#(
    parameter int PIX_BITS = PIX_BITS_DEF,
    parameter int OBJ_W    = OBJ_W_DEF
) (
    input  logic                      clk,
    input  logic                      RESETn,
    input  logic                      ce,
    input  logic                      LINE_START,
    input  logic                      OBJ_VALID,
    input  logic                      MATCHn,
    input  logic [7:0]                HPOS,
    input  logic [OBJ_W*PIX_BITS-1:0] PIXDATA,
    input  logic [7:0]                HC,
    output logic                      BUSY,
    output logic [PIX_BITS-1:0]       MO_PIX,
    output logic                      COLL
);

    localparam int CNT_W = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OBJ_W - 1);

    mo_state_e                 state_q;
    logic                      busy_q;
    logic                      wsel_q;
    logic                      rsel_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [7:0]                hpos_q;
    logic [OBJ_W*PIX_BITS-1:0] pix_q;

    logic [8:0]          addr;
    logic                carry;
    logic [PIX_BITS-1:0] cur_pix;
    logic [PIX_BITS-1:0] existing;
    logic                opaque;
    logic                occupied;
    logic                plot;
    logic                rd_req;
    logic [PIX_BITS-1:0] rdata [2];

    // Pixel i lands at HPOS+i; a carry means it fell off the right edge.
    assign addr     = {1'b0, hpos_q} + {{(9-CNT_W){1'b0}}, cnt_q};
    assign carry    = addr[8];
    assign cur_pix  = pix_q[PIX_BITS-1:0];
    assign existing = rdata[wsel_q];
    assign opaque   = cur_pix != {PIX_BITS{1'b0}};
    assign occupied = existing != {PIX_BITS{1'b0}};

    // Earlier-scanned objects win: only fill empty locations.
    assign plot   = ce & (state_q == WR) & ~LINE_START
                  & ~carry & opaque & ~occupied;
    assign rd_req = ce & (state_q == RD) & ~LINE_START;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic rd_side;
        assign rd_side = wsel_q ^ 1'(b);

        mo_linebuf_ram #(
            .DW(PIX_BITS)
        ) u_ram (
            .clk_i  (clk),
            .rst_ni (RESETn),
            .we_i   (rd_side ? ce : plot),
            .waddr_i(rd_side ? HC : addr[7:0]),
            .wdata_i(rd_side ? {PIX_BITS{1'b0}} : cur_pix),
            .re_i   (rd_side ? ce : rd_req),
            .raddr_i(rd_side ? HC : addr[7:0]),
            .rdata_o(rdata[b])
        );
    end

    // Draw sequencer plus bank select; LINE_START swaps and aborts.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b1;
            cnt_q   <= '0;
            hpos_q  <= '0;
            pix_q   <= '0;
        end else if (ce) begin
            rsel_q <= ~wsel_q;
            if (LINE_START) begin
                wsel_q  <= ~wsel_q;
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (OBJ_VALID && !MATCHn) begin
                            hpos_q  <= HPOS;
                            pix_q   <= PIXDATA;
                            cnt_q   <= '0;
                            state_q <= RD;
                            busy_q  <= 1'b1;
                        end
                    end
                    RD: begin
                        state_q <= WR;
                    end
                    WR: begin
                        if (cnt_q == LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            pix_q   <= pix_q >> PIX_BITS;
                            state_q <= RD;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign BUSY   = busy_q;
    assign MO_PIX = rdata[rsel_q];

`ifdef MO_COLLISION_EN
    logic coll_q;

    // Sticky overlap flag, cleared at the start of each line.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            coll_q <= 1'b0;
        end else if (ce) begin
            if (LINE_START) begin
                coll_q <= 1'b0;
            end else if (state_q == WR && !carry && opaque && occupied) begin
                coll_q <= 1'b1;
            end
        end
    end

    assign COLL = coll_q;
`else
    assign COLL = 1'b0;
`endif

endmodule

// File: tb/tb_mo_line_buffer_writer.sv
// Directed bench for mo_line_buffer_writer.
// Draws objects, swaps banks and sweeps HC against hand-made tables.
module tb_mo_line_buffer_writer;

    logic        clk = 1'b0;
    logic        RESETn = 1'b0;
    logic        ce = 1'b1;
    logic        LINE_START = 1'b0;
    logic        OBJ_VALID = 1'b0;
    logic        MATCHn = 1'b1;
    logic [7:0]  HPOS = '0;
    logic [31:0] PIXDATA = '0;
    logic [7:0]  HC = '0;
    logic        BUSY;
    logic [3:0]  MO_PIX;
    logic        COLL;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_pix [256];

`ifdef MO_COLLISION_EN
    localparam logic COLL_EXP = 1'b1;
`else
    localparam logic COLL_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    mo_line_buffer_writer dut (
        .clk       (clk),
        .RESETn    (RESETn),
        .ce        (ce),
        .LINE_START(LINE_START),
        .OBJ_VALID (OBJ_VALID),
        .MATCHn    (MATCHn),
        .HPOS      (HPOS),
        .PIXDATA   (PIXDATA),
        .HC        (HC),
        .BUSY      (BUSY),
        .MO_PIX    (MO_PIX),
        .COLL      (COLL)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic line_start();
        LINE_START = 1'b1;
        step();
        LINE_START = 1'b0;
    endtask

    task automatic draw(input logic [7:0] x, input logic [31:0] px,
                        input string tag);
        int n = 0;
        HPOS = x;
        PIXDATA = px;
        MATCHn = 1'b0;
        OBJ_VALID = 1'b1;
        step();
        OBJ_VALID = 1'b0;
        MATCHn = 1'b1;
        while (BUSY && n < 40) begin
            n++;
            step();
        end
        check({tag, "_busy_ce"}, n, 16);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 256; i++) exp_pix[i] = '0;
    endtask

    task automatic flush();
        for (int h = 0; h < 256; h++) begin
            HC = 8'(h);
            step();
        end
        HC = '0;
    endtask

    task automatic sweep(input string tag);
        for (int h = 0; h < 256; h++) begin
            HC = 8'(h);
            step();
            check($sformatf("%s_hc%02x", tag, h), MO_PIX, exp_pix[h]);
        end
        HC = '0;
    endtask

    initial begin
        repeat (2) step();
        check("rst_busy", BUSY, 0);
        check("rst_pix", MO_PIX, 0);
        check("rst_coll", COLL, 0);
        RESETn = 1'b1;
        step();

        // Scrub both banks before relying on their contents.
        flush();
        line_start();
        flush();
        line_start();

        // Basic draw, then clear-on-read.
        draw(8'h10, 32'h87654321, "t2");
        line_start();
        clear_exp();
        for (int i = 0; i < 8; i++) exp_pix[8'h10 + i] = 4'(i + 1);
        sweep("t2");
        for (int h = 8'h10; h < 8'h18; h++) begin
            HC = 8'(h);
            step();
            check($sformatf("t2_reread_%02x", h), MO_PIX, 0);
        end
        HC = '0;

        // Object not on this line.
        HPOS = 8'h40;
        PIXDATA = 32'h87654321;
        MATCHn = 1'b1;
        OBJ_VALID = 1'b1;
        step();
        OBJ_VALID = 1'b0;
        check("t3_busy0", BUSY, 0);
        step();
        check("t3_busy1", BUSY, 0);
        line_start();
        clear_exp();
        sweep("t3");

        // Right-edge clipping.
        draw(8'hFC, 32'h87654321, "t4");
        line_start();
        clear_exp();
        for (int i = 0; i < 4; i++) exp_pix[8'hFC + i] = 4'(i + 1);
        sweep("t4");

        // Priority and collision.
        draw(8'h20, 32'h55555555, "t5a");
        draw(8'h24, 32'h33333300, "t5b");
        check("t5_coll", COLL, 32'(COLL_EXP));
        line_start();
        check("t5_coll_clr", COLL, 0);
        clear_exp();
        for (int i = 8'h20; i < 8'h28; i++) exp_pix[i] = 4'd5;
        for (int i = 8'h28; i < 8'h2C; i++) exp_pix[i] = 4'd3;
        sweep("t5");

        // Abort on the 5th ce of a draw.
        HPOS = 8'h60;
        PIXDATA = 32'h87654321;
        MATCHn = 1'b0;
        OBJ_VALID = 1'b1;
        step();
        OBJ_VALID = 1'b0;
        MATCHn = 1'b1;
        check("t6_busy_start", BUSY, 1);
        repeat (4) step();
        check("t6_busy_mid", BUSY, 1);
        LINE_START = 1'b1;
        step();
        LINE_START = 1'b0;
        check("t6_busy_abort", BUSY, 0);
        clear_exp();
        exp_pix[8'h60] = 4'd1;
        exp_pix[8'h61] = 4'd2;
        sweep("t6");

        // Swap coincident with OBJ_VALID drops the object.
        HPOS = 8'h70;
        PIXDATA = 32'h87654321;
        MATCHn = 1'b0;
        OBJ_VALID = 1'b1;
        LINE_START = 1'b1;
        step();
        OBJ_VALID = 1'b0;
        LINE_START = 1'b0;
        MATCHn = 1'b1;
        check("t7_busy", BUSY, 0);
        clear_exp();
        sweep("t7a");
        line_start();
        sweep("t7b");

        // Reset in the middle of a draw while readout is active.
        draw(8'h50, 32'h77777777, "t1a");
        line_start();
        HC = 8'h50;
        HPOS = 8'h90;
        PIXDATA = 32'h11111111;
        MATCHn = 1'b0;
        OBJ_VALID = 1'b1;
        step();
        OBJ_VALID = 1'b0;
        MATCHn = 1'b1;
        check("t1_pix_pre", MO_PIX, 7);
        check("t1_busy_pre", BUSY, 1);
        HC = 8'h51;
        step();
        check("t1_pix_pre2", MO_PIX, 7);
        #2;
        RESETn = 1'b0;
        #1;
        check("t1_busy_rst", BUSY, 0);
        check("t1_pix_rst", MO_PIX, 0);
        check("t1_coll_rst", COLL, 0);
        step();
        RESETn = 1'b1;
        step();
        check("t1_busy_rel", BUSY, 0);
        draw(8'h30, 32'h87654321, "t1b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
